// File: rtl/cvi_pattern_source.sv
// Programmable progressive raster generator driving a clocked-video-input style
// parallel stream, with solid/ramp/bars/checker test patterns and frame tracking.
module cvi_pattern_source #(
    parameter int H_ACTIVE         = 720,
    parameter int H_FP             = 16,
    parameter int H_SYNC           = 62,
    parameter int H_BP             = 60,
    parameter int V_ACTIVE         = 480,
    parameter int V_FP             = 9,
    parameter int V_SYNC           = 6,
    parameter int V_BP             = 30,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        pix_ce_i,
    input  logic [1:0]  pattern_sel_i,
    output logic [7:0]  vid_data_o,
    output logic        vid_de_o,
    output logic        vid_datavalid_o,
    output logic        vid_locked_o,
    output logic        vid_f_o,
    output logic        vid_h_sync_o,
    output logic        vid_v_sync_o,
    output logic [7:0]  vid_color_encoding_o,
    output logic [7:0]  vid_bit_width_o,
    output logic        sof_o,
    output logic [15:0] frame_count_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are kept at least 8/5 bits wide so the ramp and checker taps always exist.
    localparam int HW  = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int VW  = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;
    localparam int SEG = H_ACTIVE / 8;
    localparam int SW  = (SEG > 1) ? $clog2(SEG) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SEG_LAST   = SW'(SEG - 1);
    localparam logic          SYNC_ON    = SYNC_ACTIVE_HIGH;
    localparam logic          SYNC_OFF   = ~SYNC_ACTIVE_HIGH;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d, hn_s;
    logic [VW-1:0] v_q, v_d, vn_s;
    logic [SW-1:0] seg_q, seg_d;
    logic [2:0]    bar_q, bar_d;
    logic [1:0]    pat_q, pat_d;
    logic          locked_q, locked_d;
    logic [7:0]    data_q, data_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          dv_q, dv_d;
    logic          sof_q, sof_d;
    logic [15:0]   fc_q, fc_d;
    logic          emit_s, idle_s;

    function automatic logic [7:0] pattern_pixel(input logic [1:0] sel, input logic [7:0] h,
                                                 input logic v4, input logic [2:0] bar);
        logic [7:0] px;
        case (sel)
            2'd0:    px = 8'h80;
            2'd1:    px = h;
            2'd2:    px = {bar, 5'b00000};
            2'd3:    px = (h[4] ^ v4) ? 8'hEB : 8'h10;
            default: px = 8'h00;
        endcase
        return px;
    endfunction

    // Raster sequencing: h_q/v_q hold the position of the pixel currently on the outputs.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        seg_d    = seg_q;
        bar_d    = bar_q;
        pat_d    = pat_q;
        locked_d = locked_q;
        data_d   = data_q;
        de_d     = de_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        fc_d     = fc_q;
        dv_d     = 1'b0;
        sof_d    = 1'b0;
        emit_s   = 1'b0;
        idle_s   = 1'b0;
        hn_s     = '0;
        vn_s     = '0;

        case (state_q)
            ST_IDLE: begin
                if (pix_ce_i && enable_i) begin
                    emit_s = 1'b1;
                end else begin
                    emit_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (pix_ce_i) begin
                    if (h_q == H_LAST) begin
                        hn_s = '0;
                        if (v_q == V_LAST) begin
                            vn_s   = '0;
                            emit_s = enable_i;
                            idle_s = ~enable_i;
                        end else begin
                            vn_s   = v_q + 1'b1;
                            emit_s = 1'b1;
                        end
                    end else begin
                        hn_s   = h_q + 1'b1;
                        vn_s   = v_q;
                        emit_s = 1'b1;
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            default: idle_s = 1'b1;
        endcase

        if (emit_s) begin
            state_d = ST_RUN;
            h_d     = hn_s;
            v_d     = vn_s;
            dv_d    = 1'b1;
            if ((hn_s == '0) && (vn_s == '0)) begin
                sof_d    = 1'b1;
                fc_d     = fc_q + 16'd1;
                pat_d    = pattern_sel_i;
                locked_d = (state_q == ST_RUN);
            end else begin
                pat_d    = pat_q;
            end
            if (hn_s == '0) begin
                bar_d = 3'd0;
                seg_d = '0;
            end else if (seg_q == SEG_LAST) begin
                bar_d = bar_q + 3'd1;
                seg_d = '0;
            end else begin
                bar_d = bar_q;
                seg_d = seg_q + 1'b1;
            end
            de_d   = (hn_s < H_ACT_END) && (vn_s < V_ACT_END);
            hs_d   = ((hn_s >= H_SYNC_BEG) && (hn_s < H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
            vs_d   = ((vn_s >= V_SYNC_BEG) && (vn_s < V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
            data_d = de_d ? pattern_pixel(pat_d, hn_s[7:0], vn_s[4], bar_d) : 8'h00;
        end else if (idle_s) begin
            state_d  = ST_IDLE;
            h_d      = '0;
            v_d      = '0;
            seg_d    = '0;
            bar_d    = 3'd0;
            locked_d = 1'b0;
            data_d   = 8'h00;
            de_d     = 1'b0;
            hs_d     = SYNC_OFF;
            vs_d     = SYNC_OFF;
        end else begin
            state_d  = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            seg_q    <= '0;
            bar_q    <= 3'd0;
            pat_q    <= 2'd0;
            locked_q <= 1'b0;
            data_q   <= 8'h00;
            de_q     <= 1'b0;
            hs_q     <= SYNC_OFF;
            vs_q     <= SYNC_OFF;
            dv_q     <= 1'b0;
            sof_q    <= 1'b0;
            fc_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            seg_q    <= seg_d;
            bar_q    <= bar_d;
            pat_q    <= pat_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            dv_q     <= dv_d;
            sof_q    <= sof_d;
            fc_q     <= fc_d;
        end
    end

    assign vid_data_o           = data_q;
    assign vid_de_o             = de_q;
    assign vid_datavalid_o      = dv_q;
    assign vid_locked_o         = locked_q;
    assign vid_f_o              = 1'b0;
    assign vid_h_sync_o         = hs_q;
    assign vid_v_sync_o         = vs_q;
    assign vid_color_encoding_o = 8'h00;
    assign vid_bit_width_o      = 8'd8;
    assign sof_o                = sof_q;
    assign frame_count_o        = fc_q;

endmodule

// File: tb/tb_cvi_pattern_source.sv
// Directed bench for cvi_pattern_source on a reduced 24x8 raster.
module tb_cvi_pattern_source;

    localparam int HA = 16, HF = 2, HS = 2, HB = 4, HT = 24;
    localparam int VA = 4, VF = 1, VS = 1, VB = 2, VT = 8;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        pix_ce = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [7:0]  vid_data, vid_color_encoding, vid_bit_width;
    logic        vid_de, vid_datavalid, vid_locked, vid_f, vid_h_sync, vid_v_sync, sof;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cvi_pattern_source #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_HIGH(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable), .pix_ce_i(pix_ce),
        .pattern_sel_i(sel), .vid_data_o(vid_data), .vid_de_o(vid_de),
        .vid_datavalid_o(vid_datavalid), .vid_locked_o(vid_locked), .vid_f_o(vid_f),
        .vid_h_sync_o(vid_h_sync), .vid_v_sync_o(vid_v_sync),
        .vid_color_encoding_o(vid_color_encoding), .vid_bit_width_o(vid_bit_width),
        .sof_o(sof), .frame_count_o(frame_count)
    );

    wire [12:0] obs = {vid_data, vid_de, vid_h_sync, vid_v_sync, vid_datavalid, sof};
    localparam logic [12:0] IDLE_VEC = {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    function automatic logic [7:0] exp_data(input int s, input int h, input int v);
        if (!(h < HA && v < VA)) return 8'h00;
        case (s)
            0:       return 8'h80;
            1:       return 8'(h);
            2:       return 8'((h / (HA / 8)) * 32);
            default: return ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 8'hEB : 8'h10;
        endcase
    endfunction

    // Expected {data, de, hsync, vsync, datavalid, sof} for pixel k of a frame.
    function automatic logic [12:0] exp_pix(input int s, input int k, input logic dv, input logic sf);
        int h, v;
        h = k % HT;
        v = (k / HT) % VT;
        return {exp_data(s, h, v), (h < HA && v < VA), !(h >= HA + HF && h < HA + HF + HS),
                !(v >= VA + VF && v < VA + VF + VS), dv, sf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        pix_ce = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_stream got %h exp %h", obs, IDLE_VEC);
        end
        checks++;
        if ({vid_locked, vid_f, frame_count} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_status got %b %b %h exp 0 0 0000", vid_locked, vid_f, frame_count);
        end
        checks++;
        if ({vid_color_encoding, vid_bit_width} !== {8'h00, 8'd8}) begin
            errors++;
            $display("FAIL constants got %h %h exp 00 08", vid_color_encoding, vid_bit_width);
        end
        reset_n = 1'b1;
        pix_ce = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL idle_no_enable got %h exp %h", obs, IDLE_VEC);
        end
    endtask

    // Three continuous frames of the ramp pattern: raster timing, sof, lock and count.
    task automatic test_raster();
        sel = 2'd1;
        enable = 1'b1;
        pix_ce = 1'b1;
        for (int k = 0; k < 3 * FR; k++) begin
            tick();
            checks++;
            if (obs !== exp_pix(1, k, 1'b1, (k % FR) == 0)) begin
                errors++;
                $display("FAIL raster k=%0d got %h exp %h", k, obs, exp_pix(1, k, 1'b1, (k % FR) == 0));
            end
            checks++;
            if ({vid_locked, frame_count} !== {(k >= FR), 16'(k / FR + 1)}) begin
                errors++;
                $display("FAIL lock_count k=%0d got %b %0d exp %b %0d", k, vid_locked, frame_count,
                         (k >= FR), k / FR + 1);
            end
        end
    endtask

    task automatic test_stop();
        for (int k = 0; k < FR; k++) begin
            if (k == 50) enable = 1'b0;
            tick();
            checks++;
            if ({obs, vid_locked, frame_count} !== {exp_pix(1, k, 1'b1, k == 0), 1'b1, 16'd4}) begin
                errors++;
                $display("FAIL stop_frame k=%0d got %h %b %0d exp %h 1 4", k, obs, vid_locked,
                         frame_count, exp_pix(1, k, 1'b1, k == 0));
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({obs, vid_locked, frame_count} !== {IDLE_VEC, 1'b0, 16'd4}) begin
                errors++;
                $display("FAIL stop_idle i=%0d got %h %b %0d exp %h 0 4", i, obs, vid_locked,
                         frame_count, IDLE_VEC);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({obs, vid_locked, frame_count} !== {exp_pix(1, 0, 1'b1, 1'b1), 1'b0, 16'd5}) begin
            errors++;
            $display("FAIL restart got %h %b %0d exp %h 0 5", obs, vid_locked, frame_count,
                     exp_pix(1, 0, 1'b1, 1'b1));
        end
    endtask

    task automatic test_pix_ce();
        do_reset();
        sel = 2'd1;
        enable = 1'b1;
        for (int j = 0; j <= 3 * FR; j++) begin
            pix_ce = ((j % 3) == 0);
            tick();
            checks++;
            if (obs !== exp_pix(1, (j / 3) % FR, (j % 3) == 0, (j % (3 * FR)) == 0)) begin
                errors++;
                $display("FAIL pix_ce j=%0d got %h exp %h", j, obs,
                         exp_pix(1, (j / 3) % FR, (j % 3) == 0, (j % (3 * FR)) == 0));
            end
        end
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL pix_ce_count got %0d exp 2", frame_count);
        end
    endtask

    // Bars, then checker, then solid; sel is changed mid-frame each time.
    task automatic test_patterns();
        int fsel;
        do_reset();
        sel = 2'd2;
        enable = 1'b1;
        pix_ce = 1'b1;
        for (int k = 0; k < 3 * FR; k++) begin
            fsel = (k < FR) ? 2 : ((k < 2 * FR) ? 3 : 0);
            if (k == 100) sel = 2'd3;
            if (k == FR + 100) sel = 2'd0;
            tick();
            checks++;
            if (obs !== exp_pix(fsel, k % FR, 1'b1, (k % FR) == 0)) begin
                errors++;
                $display("FAIL pattern sel=%0d k=%0d got %h exp %h", fsel, k, obs,
                         exp_pix(fsel, k % FR, 1'b1, (k % FR) == 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel = 2'd1;
        enable = 1'b1;
        pix_ce = 1'b1;
        for (int k = 0; k <= 100; k++) tick();
        checks++;
        if ({obs, frame_count} !== {exp_pix(1, 100, 1'b1, 1'b0), 16'd1}) begin
            errors++;
            $display("FAIL pre_reset got %h %0d exp %h 1", obs, frame_count, exp_pix(1, 100, 1'b1, 1'b0));
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({obs, vid_locked, vid_f, frame_count} !== {IDLE_VEC, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL mid_reset got %h %b %b %0d exp %h 0 0 0", obs, vid_locked, vid_f,
                     frame_count, IDLE_VEC);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({obs, frame_count} !== {exp_pix(1, 0, 1'b1, 1'b1), 16'd1}) begin
            errors++;
            $display("FAIL post_reset got %h %0d exp %h 1", obs, frame_count, exp_pix(1, 0, 1'b1, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_stop();
        test_pix_ce();
        test_patterns();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
